// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
//
// Writeback stage of the RV32I core. Takes one completed instruction at a
// time from execute over a valid/ready handshake. Non-loads are written back
// on the next cycle. Legal, aligned loads issue a word read to data memory
// and wait for the acknowledge. They then sign- or zero-extend the addressed
// byte or halfword. Illegal or misaligned loads skip memory entirely and
// retire with a fault pulse.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready handshake from execute (in_ready = IDLE && !rst)
//   in_rd, in_wb_en   destination register and its write enable
//   in_is_load        instruction is a load; in_result is then the address
//   in_funct3         load type (LB/LH/LW/LBU/LHU)
//   in_result         ALU result or load effective address
//   mem_req/mem_addr  word-aligned data-memory read request
//   mem_ack/mem_rdata read data valid / read data
//   is_write, wb_addr, wb_data   single-cycle register-file write strobe
//   retire            one pulse per completed instruction
//   load_fault        one pulse per illegal or misaligned load
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_wb_en,
    input  logic            in_is_load,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_result,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            is_write,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            retire,
    output logic            load_fault
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WRITE    = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    state_e            state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_en_q, wb_en_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lo_q, lo_d;        // address byte offset, used for extraction
    logic              fault_q, fault_d;
    logic              mem_req_q, mem_req_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic [4:0]        wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              load_legal;
    logic              load_misaligned;

    // Pick the addressed byte/halfword out of the read word and extend it.
    function automatic logic [XLEN-1:0] extract(input logic [2:0]      f3,
                                                input logic [1:0]      lo,
                                                input logic [XLEN-1:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lo[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            F3_LB:   extract = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  extract = {{(XLEN-8){1'b0}}, b};
            F3_LH:   extract = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  extract = {{(XLEN-16){1'b0}}, h};
            default: extract = rdata;
        endcase
    endfunction

    always_comb begin
        load_legal = (in_funct3 == F3_LB)  || (in_funct3 == F3_LH) ||
                     (in_funct3 == F3_LW)  || (in_funct3 == F3_LBU) ||
                     (in_funct3 == F3_LHU);
        load_misaligned = (((in_funct3 == F3_LH) || (in_funct3 == F3_LHU)) && in_result[0]) ||
                          ((in_funct3 == F3_LW) && (in_result[1:0] != 2'b00));
    end

    assign in_ready = (state_q == IDLE) && !rst;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wb_en_d    = wb_en_q;
        funct3_d   = funct3_q;
        lo_d       = lo_q;
        fault_d    = fault_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        is_write   = 1'b0;
        retire     = 1'b0;
        load_fault = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ack is deliberately ignored here: a late ack from an
                // abandoned load must not be taken as data.
                if (in_valid && in_ready) begin
                    rd_d     = in_rd;
                    wb_en_d  = in_wb_en;
                    funct3_d = in_funct3;
                    lo_d     = in_result[1:0];
                    if (!in_is_load) begin
                        fault_d   = 1'b0;
                        wb_addr_d = in_rd;
                        wb_data_d = in_result;
                        state_d   = WRITE;
                    end else if (!load_legal || load_misaligned) begin
                        // wb_data keeps its old value; the write is suppressed anyway.
                        fault_d   = 1'b1;
                        wb_addr_d = in_rd;
                        state_d   = WRITE;
                    end else begin
                        fault_d    = 1'b0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {in_result[XLEN-1:2], 2'b00};
                        state_d    = MEM_WAIT;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    wb_addr_d = rd_q;
                    wb_data_d = extract(funct3_q, lo_q, mem_rdata);
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                is_write   = wb_en_q && (rd_q != 5'd0) && !fault_q;
                retire     = 1'b1;
                load_fault = fault_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rd_q       <= '0;
            wb_en_q    <= 1'b0;
            funct3_q   <= '0;
            lo_q       <= '0;
            fault_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wb_en_q    <= wb_en_d;
            funct3_q   <= funct3_d;
            lo_q       <= lo_d;
            fault_q    <= fault_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
//
// Directed scenarios plus a randomized run for wb_stage. Expected values come
// from a behavioural model of the load rules written in plain arithmetic.
// Inputs change #1 after a rising edge, and outputs are sampled in the same
// place.
// -----------------------------------------------------------------------------
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        is_write;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        retire;
    logic        load_fault;

    int passed = 0;
    int total  = 0;

    wb_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_wb_en   (in_wb_en),
        .in_is_load (in_is_load),
        .in_funct3  (in_funct3),
        .in_result  (in_result),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .is_write   (is_write),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .retire     (retire),
        .load_fault (load_fault)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned k;
        int unsigned h;
        logic [31:0] b;
        logic [31:0] hw;
        k  = addr % 4;
        h  = (addr % 4) / 2;
        b  = (word >> (8 * k)) % 256;
        hw = (word >> (16 * h)) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (hw >= 32768) ? hw - 32'd65536 : hw;
            3'd4:    return b;
            3'd5:    return hw;
            default: return word;
        endcase
    endfunction

    function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        if (!legal) return 1'b1;
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                           input logic en, input logic [31:0] res);
        in_valid   = 1'b1;
        in_is_load = ld;
        in_funct3  = f3;
        in_rd      = rd;
        in_wb_en   = en;
        in_result  = res;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_wb_en = 1'b0; in_is_load = 1'b0;
        in_funct3 = '0; in_result = '0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_req); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h exp 0", mem_addr); else passed++;
        total++; if (wb_addr !== 5'd0) $display("FAIL reset_wb_addr got %0d exp 0", wb_addr); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL reset_wb_data got %h exp 0", wb_data); else passed++;
        total++; if ({is_write, retire, load_fault} !== 3'b000)
            $display("FAIL reset_pulses got %b exp 000", {is_write, retire, load_fault}); else passed++;
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b exp 1", in_ready); else passed++;
    endtask

    task automatic test_alu();
        present(1'b0, 3'd0, 5'd5, 1'b1, 32'h1234_5678);
        tick();
        in_valid = 1'b0;
        total++; if (is_write !== 1'b1) $display("FAIL alu_is_write got %b exp 1", is_write); else passed++;
        total++; if (wb_addr !== 5'd5) $display("FAIL alu_wb_addr got %0d exp 5", wb_addr); else passed++;
        total++; if (wb_data !== 32'h1234_5678) $display("FAIL alu_wb_data got %h exp 12345678", wb_data); else passed++;
        total++; if (retire !== 1'b1) $display("FAIL alu_retire got %b exp 1", retire); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL alu_in_ready_low got %b exp 0", in_ready); else passed++;
        tick();
        total++; if (in_ready !== 1'b1) $display("FAIL alu_in_ready_back got %b exp 1", in_ready); else passed++;
        total++; if ({is_write, retire} !== 2'b00) $display("FAIL alu_single_pulse got %b exp 00", {is_write, retire}); else passed++;
        total++; if (wb_data !== 32'h1234_5678) $display("FAIL alu_wb_data_hold got %h exp 12345678", wb_data); else passed++;
    endtask

    task automatic test_rd0();
        present(1'b0, 3'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        tick();
        in_valid = 1'b0;
        total++; if (is_write !== 1'b0) $display("FAIL rd0_is_write got %b exp 0", is_write); else passed++;
        total++; if (retire !== 1'b1) $display("FAIL rd0_retire got %b exp 1", retire); else passed++;
        tick();
    endtask

    task automatic test_lb_lbu();
        logic [2:0]  f3s [2] = '{3'd0, 3'd4};
        logic [31:0] exps[2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            present(1'b1, f3s[i], 5'd10, 1'b1, 32'h0000_0103);
            tick();
            in_valid = 1'b0;
            total++; if (mem_req !== 1'b1) $display("FAIL lb%0d_mem_req got %b exp 1", i, mem_req); else passed++;
            total++; if (mem_addr !== 32'h100) $display("FAIL lb%0d_mem_addr got %h exp 00000100", i, mem_addr); else passed++;
            total++; if (retire !== 1'b0) $display("FAIL lb%0d_early_retire got %b exp 0", i, retire); else passed++;
            mem_ack = 1'b1; mem_rdata = 32'h80AB_CD12;
            tick();
            mem_ack = 1'b0; mem_rdata = $urandom;
            total++; if (is_write !== 1'b1) $display("FAIL lb%0d_is_write got %b exp 1", i, is_write); else passed++;
            total++; if (wb_data !== exps[i]) $display("FAIL lb%0d_wb_data got %h exp %h", i, wb_data, exps[i]); else passed++;
            total++; if (mem_req !== 1'b0) $display("FAIL lb%0d_mem_req_drop got %b exp 0", i, mem_req); else passed++;
            tick();
        end
    endtask

    task automatic test_lh_wait();
        present(1'b1, 3'd1, 5'd7, 1'b1, 32'h0000_0202);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (mem_req !== 1'b1) $display("FAIL lh_mem_req_c%0d got %b exp 1", i, mem_req); else passed++;
            total++; if (mem_addr !== 32'h200) $display("FAIL lh_mem_addr_c%0d got %h exp 00000200", i, mem_addr); else passed++;
            total++; if (is_write !== 1'b0) $display("FAIL lh_early_write_c%0d got %b exp 0", i, is_write); else passed++;
            if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'h9ABC_0000; end
            tick();
        end
        mem_ack = 1'b0;
        total++; if (is_write !== 1'b1) $display("FAIL lh_is_write got %b exp 1", is_write); else passed++;
        total++; if (wb_addr !== 5'd7) $display("FAIL lh_wb_addr got %0d exp 7", wb_addr); else passed++;
        total++; if (wb_data !== 32'hFFFF_9ABC) $display("FAIL lh_wb_data got %h exp ffff9abc", wb_data); else passed++;
        tick();
    endtask

    task automatic test_fault();
        logic [2:0]  f3s  [2] = '{3'd2, 3'd3};
        logic [31:0] addrs[2] = '{32'h0000_0006, 32'h0000_0100};
        for (int i = 0; i < 2; i++) begin
            present(1'b1, f3s[i], 5'd12, 1'b1, addrs[i]);
            tick();
            in_valid = 1'b0;
            total++; if (mem_req !== 1'b0) $display("FAIL fault%0d_mem_req got %b exp 0", i, mem_req); else passed++;
            total++; if (load_fault !== 1'b1) $display("FAIL fault%0d_load_fault got %b exp 1", i, load_fault); else passed++;
            total++; if (retire !== 1'b1) $display("FAIL fault%0d_retire got %b exp 1", i, retire); else passed++;
            total++; if (is_write !== 1'b0) $display("FAIL fault%0d_is_write got %b exp 0", i, is_write); else passed++;
            tick();
            total++; if ({mem_req, load_fault, retire} !== 3'b000)
                $display("FAIL fault%0d_after got %b exp 000", i, {mem_req, load_fault, retire}); else passed++;
            total++; if (in_ready !== 1'b1) $display("FAIL fault%0d_in_ready got %b exp 1", i, in_ready); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        present(1'b0, 3'd0, 5'd3, 1'b1, 32'h0000_000A);
        tick();
        present(1'b0, 3'd0, 5'd4, 1'b1, 32'h0000_000B);   // held while in_ready is low
        total++; if (wb_addr !== 5'd3 || retire !== 1'b1)
            $display("FAIL b2b_first got rd %0d retire %b exp rd 3 retire 1", wb_addr, retire); else passed++;
        tick();
        total++; if ({is_write, retire} !== 2'b00) $display("FAIL b2b_gap got %b exp 00", {is_write, retire}); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", in_ready); else passed++;
        tick();
        in_valid = 1'b0;
        total++; if (is_write !== 1'b1 || wb_addr !== 5'd4 || wb_data !== 32'hB)
            $display("FAIL b2b_second got w %b rd %0d data %h exp w 1 rd 4 data 0000000b", is_write, wb_addr, wb_data); else passed++;
        tick();
        total++; if (retire !== 1'b0) $display("FAIL b2b_no_dup got %b exp 0", retire); else passed++;
    endtask

    task automatic test_reset_mid_load();
        present(1'b1, 3'd2, 5'd8, 1'b1, 32'h0000_0300);
        tick();
        in_valid = 1'b0;
        total++; if (mem_req !== 1'b1) $display("FAIL rml_mem_req got %b exp 1", mem_req); else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (mem_req !== 1'b0) $display("FAIL rml_mem_req_drop got %b exp 0", mem_req); else passed++;
        total++; if ({is_write, retire} !== 2'b00) $display("FAIL rml_no_retire got %b exp 00", {is_write, retire}); else passed++;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack = 1'b0;
        total++; if ({is_write, retire, mem_req} !== 3'b000)
            $display("FAIL rml_late_ack got %b exp 000", {is_write, retire, mem_req}); else passed++;
        tick();
        total++; if ({is_write, retire} !== 2'b00) $display("FAIL rml_late_ack2 got %b exp 00", {is_write, retire}); else passed++;
        present(1'b0, 3'd0, 5'd9, 1'b1, 32'h0000_0055);
        tick();
        in_valid = 1'b0;
        total++; if (is_write !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h55)
            $display("FAIL rml_next_alu got w %b rd %0d data %h exp w 1 rd 9 data 00000055", is_write, wb_addr, wb_data); else passed++;
        tick();
    endtask

    task automatic test_random();
        logic [2:0]  legal_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            int unsigned waits;
            logic [2:0]  f3;
            logic [31:0] addr;
            logic [31:0] word;
            logic [4:0]  rd;
            logic        en;
            logic        ld;
            bit          flt;
            logic [31:0] exp_data;
            bit          exp_write;
            kind  = $urandom_range(0, 2);
            waits = $urandom_range(0, 3);
            rd    = 5'($urandom);
            en    = 1'($urandom);
            addr  = $urandom;
            word  = $urandom;
            ld    = (kind != 0);
            f3    = 3'($urandom);
            if (kind == 1) begin
                f3 = legal_f3[$urandom_range(0, 4)];
                if (f3 == 3'd2) addr = addr - (addr % 4);
                else if (f3 == 3'd1 || f3 == 3'd5) addr = addr - (addr % 2);
            end
            flt       = ld && model_fault(f3, addr);
            exp_data  = ld ? model_load(f3, addr, word) : addr;
            exp_write = en && (rd != 0) && !flt;

            present(ld, f3, rd, en, addr);
            tick();
            in_valid = 1'b0;
            if (ld && !flt) begin
                for (int w = 0; w <= int'(waits); w++) begin
                    total++; if (mem_req !== 1'b1 || mem_addr !== addr - (addr % 4))
                        $display("FAIL rnd%0d_mem got req %b addr %h exp req 1 addr %h", n, mem_req, mem_addr, addr - (addr % 4));
                    else passed++;
                    if (w == int'(waits)) begin mem_ack = 1'b1; mem_rdata = word; end
                    tick();
                end
                mem_ack = 1'b0;
            end else begin
                total++; if (mem_req !== 1'b0) $display("FAIL rnd%0d_no_req got %b exp 0", n, mem_req); else passed++;
            end
            total++; if (retire !== 1'b1 || load_fault !== flt || is_write !== exp_write)
                $display("FAIL rnd%0d_strobes got r %b f %b w %b exp r 1 f %b w %b", n, retire, load_fault, is_write, flt, exp_write);
            else passed++;
            if (!flt) begin
                total++; if (wb_data !== exp_data || wb_addr !== rd)
                    $display("FAIL rnd%0d_data got rd %0d data %h exp rd %0d data %h", n, wb_addr, wb_data, rd, exp_data);
                else passed++;
            end
            tick();
            total++; if (in_ready !== 1'b1 || retire !== 1'b0)
                $display("FAIL rnd%0d_idle got ready %b retire %b exp 1 0", n, in_ready, retire); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_rd0();
        test_lb_lbu();
        test_lh_wait();
        test_fault();
        test_back_to_back();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog: the scenarios are self-timed, so this only fires on a hung simulator.
    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I core, directly upstream of the register file write port. Accepts one completed instruction at a time from execute over a valid/ready handshake. For loads, it issues a word read to data memory, waits for the acknowledge, then extracts and sign- or zero-extends the addressed byte or halfword. It drives a single-cycle register-file write strobe (`is_write`/`wb_addr`/`wb_data`) and a retire pulse.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports (name, direction, width, meaning):
- `clk` in 1: clock. Single clock domain; everything is sampled on its rising edge.
- `rst` in 1: reset. Synchronous, active-high.
- `in_valid` in 1: execute presents an instruction.
- `in_ready` out 1: stage can accept. Equals `state==IDLE && !rst`.
- `in_rd` in 5: destination register.
- `in_wb_en` in 1: the instruction writes `rd`.
- `in_is_load` in 1: the instruction is a load; `in_result` is then the effective address.
- `in_funct3` in 3: load type. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `in_result` in 32: ALU result, or load address.
- `mem_req` out 1: data-memory read request.
- `mem_addr` out 32: word-aligned read address.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in 32: read data.
- `is_write` out 1: register-file write strobe.
- `wb_addr` out 5: register-file write address.
- `wb_data` out 32: register-file write data.
- `retire` out 1: one-cycle pulse per completed instruction.
- `load_fault` out 1: one-cycle pulse for a misaligned or illegal load.

## Operation
- FSM states: IDLE, MEM_WAIT, WRITE.
- **IDLE**
  - On `in_valid && in_ready`, capture `in_rd`, `in_wb_en`, `in_funct3`, `in_result`.
  - Non-load: go to WRITE with `wb_data = in_result`.
  - Load, legal and aligned: go to MEM_WAIT. Register `mem_req=1` and `mem_addr={in_result[31:2],2'b00}`.
  - Load, illegal: go to WRITE with the write suppressed and `load_fault` set. Illegal means either:
    - `funct3` ∈ {011,110,111}, or
    - misaligned: LH/LHU with `addr[0]=1`, or LW with `addr[1:0]≠0`.
  - `mem_ack` in IDLE is ignored.
- **MEM_WAIT**
  - `mem_req` and `mem_addr` are held stable until `mem_ack`.
  - On `mem_ack`: register the extracted data, drop `mem_req`, go to WRITE.
- **Load extraction** (`k = addr[1:0]`, `h = addr[1]`):
  - LB: sign-extend `rdata[8k+7:8k]`.
  - LBU: zero-extend `rdata[8k+7:8k]`.
  - LH: sign-extend `rdata[16h+15:16h]`.
  - LHU: zero-extend `rdata[16h+15:16h]`.
  - LW: `rdata` unchanged.
- **WRITE** (exactly one cycle, then back to IDLE):
  - `is_write = wb_en && rd≠0 && !fault`.
  - `wb_addr = rd`; `wb_data` = captured or extracted value.
  - `retire=1` always, including `rd=0` and fault cases.
  - `load_fault=1` only on fault.
- **Outputs outside WRITE:** `is_write`, `retire`, `load_fault` are 0. `wb_addr`/`wb_data` hold their last value.

## Timing
- **Reset:** state IDLE; `mem_req`, `is_write`, `retire`, `load_fault` = 0; `mem_addr`, `wb_addr`, `wb_data` = 0; `in_ready=0` while `rst=1`.
- **Non-load:** accepted at edge N; `is_write`/`retire` high in cycle N+1; `in_ready` high again in N+2. Throughput is one instruction per 2 cycles.
- **Load:** accepted at edge N; `mem_req` high from cycle N+1.
  - `mem_ack` may arrive in cycle N+1 at the earliest (zero wait).
  - If ack arrives in cycle N+1+w, the write happens in N+2+w.
  - Minimum load latency is 2 cycles to the write.
- **Faulting load:** `mem_req` is never raised; `load_fault`/`retire` pulse in N+1.
- **Reset mid-load:** the load is abandoned and `mem_req=0` on the next cycle. No write or retire is produced. A late `mem_ack` after reset is ignored.
- **Backpressure:** `in_valid` seen while `in_ready=0` is not consumed. The upstream stage holds its inputs stable.

## Test plan
- **ALU writeback:** rd=5, result=0x1234_5678, wb_en=1 → next cycle `is_write=1`, `wb_addr=5`, `wb_data=0x12345678`, `retire=1`; `in_ready` low for exactly 1 cycle.
- **rd=0 suppression:** rd=0, wb_en=1, result=0xFFFF_FFFF → `is_write=0`, `retire=1`.
- **LB/LBU extraction:** addr=0x0000_0103, `mem_rdata=0x80AB_CD12`.
  - `mem_addr=0x100`.
  - LB → `wb_data=0xFFFF_FF80`.
  - LBU → `0x0000_0080`.
- **LH with wait states:** addr=0x202, rdata=0x9ABC_0000, `mem_ack` after 3 wait cycles.
  - `mem_req` stays high 4 cycles with `mem_addr=0x200` stable.
  - Write one cycle after ack with `wb_data=0xFFFF_9ABC`.
- **Misaligned/illegal:** LW at 0x0000_0006 and funct3=011 → `mem_req` never asserted; `load_fault=1`, `retire=1`, `is_write=0`, one cycle after accept.
- **Reset during MEM_WAIT:** assert `rst` for 1 cycle, then pulse `mem_ack` → `mem_req=0` after reset; no `is_write`/`retire`; the next ALU op writes back normally.
